fp_mult_sched: RTL and testbench



---
 rtl/fp_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/fp_mult_sched.sv | 94 +++++++++
 tb/tb_fp_mult_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - fixed-point format constants, types and product truncation
// Purpose: shared Q8.56 format definitions for the multiplier scheduler.
// Contents: DATA_WIDTH, FRACTIONAL_BITS, INTEGER_BITS, fixed_t, product_t,
//           trunc_t and fp_trunc(product) -> {data, ovf}.
package fp_pkg;

  localparam int DATA_WIDTH      = 64;
  localparam int FRACTIONAL_BITS = 56;
  localparam int INTEGER_BITS    = DATA_WIDTH - FRACTIONAL_BITS;

  typedef logic signed [DATA_WIDTH-1:0]   fixed_t;
  typedef logic signed [2*DATA_WIDTH-1:0] product_t;

  typedef struct packed {
    fixed_t data;
    logic   ovf;
  } trunc_t;

  // Arithmetic shift keeps every product bit in use: the low word is the
  // floor-truncated result, and the upper half plus the result sign bit must
  // all match for the value to fit.
  function automatic trunc_t fp_trunc(input product_t product);
    product_t shifted;
    trunc_t   res;
    shifted  = product >>> FRACTIONAL_BITS;
    res.data = shifted[DATA_WIDTH-1:0];
    res.ovf  = ~((&shifted[2*DATA_WIDTH-1:DATA_WIDTH-1]) |
                 ~(|shifted[2*DATA_WIDTH-1:DATA_WIDTH-1]));
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with rotating priority pointer
// Purpose: picks the first requester after the last accepted one.
// Ports: clk, reset (sync, active-high), req[NUM_REQ], advance (grant taken),
//        grant[NUM_REQ] one-hot or zero, grant_idx index of the grant.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               idx;

  // Search order starts one past the pointer so the last winner goes last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  // Reset value NUM_REQ-1 gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= IDX_W'(NUM_REQ - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/fp_mult_sched.sv
// rtl/fp_mult_sched.sv - shared signed fixed-point multiplier with RR scheduling
// Purpose: arbitrates NUM_REQ requesters onto one multiplier through a
//          two-stage pipeline (operand register, product register).
// Ports: clk, reset (sync, active-high); req_valid/req_ready per requester,
//        req_a/req_b packed operands (slice i = requester i);
//        rsp_valid/rsp_ready handshake, rsp_id owner, rsp_data product,
//        rsp_ovf product out of range (data wraps).
module fp_mult_sched #(
  parameter  int NUM_REQ         = 4,
  parameter  int DATA_WIDTH      = fp_pkg::DATA_WIDTH,
  parameter  int FRACTIONAL_BITS = fp_pkg::FRACTIONAL_BITS,
  localparam int ID_W            = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_ovf
);

  import fp_pkg::*;

  logic [NUM_REQ-1:0]            grant;
  logic [ID_W-1:0]               grant_idx;
  logic                          stall;
  logic                          accept;
  logic [DATA_WIDTH-1:0]         sel_a;
  logic [DATA_WIDTH-1:0]         sel_b;

  logic signed [DATA_WIDTH-1:0]   s1_a;
  logic signed [DATA_WIDTH-1:0]   s1_b;
  logic [ID_W-1:0]                s1_id;
  logic                           s1_v;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [2*DATA_WIDTH-1:0] prod_sh;
  logic [DATA_WIDTH-1:0]          data_next;
  logic                           ovf_next;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Both stages advance together, so a held response freezes the operand
  // stage as well and no new request may be taken.
  assign stall     = rsp_valid & ~rsp_ready;
  assign req_ready = (stall | reset) ? '0 : grant;
  assign accept    = |(req_valid & req_ready);

  assign sel_a = req_a[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b = req_b[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Full-width signed product; the shift leaves the floor-truncated result in
  // the low word and range information in the bits above it.
  assign prod      = (2*DATA_WIDTH)'(s1_a) * (2*DATA_WIDTH)'(s1_b);
  assign prod_sh   = prod >>> FRACTIONAL_BITS;
  assign data_next = prod_sh[DATA_WIDTH-1:0];
  assign ovf_next  = ~((&prod_sh[2*DATA_WIDTH-1:DATA_WIDTH-1]) |
                       ~(|prod_sh[2*DATA_WIDTH-1:DATA_WIDTH-1]));

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v      <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_ovf   <= 1'b0;
    end else if (!stall) begin
      s1_v      <= accept;
      s1_a      <= sel_a;
      s1_b      <= sel_b;
      s1_id     <= grant_idx;
      rsp_valid <= s1_v;
      rsp_data  <= data_next;
      rsp_id    <= s1_id;
      rsp_ovf   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_fp_mult_sched.sv
// tb/tb_fp_mult_sched.sv - scoreboard bench for fp_mult_sched
module tb_fp_mult_sched;

  localparam int NR = 4;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a;
  logic [NR*DW-1:0]  req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              rsp_ovf;

  fp_mult_sched #(.NUM_REQ(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] data;
    logic        ovf;
  } exp_t;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
  } pend_t;

  exp_t    exp_q[$];
  pend_t   pend_q[$];
  exp_t    mon_e;
  int      n_checks = 0;
  int      n_errors = 0;
  int      cyc = 0;
  int      rsp_seen = 0;
  int      first_cyc = 0;
  int      last_cyc = 0;
  logic    rsp_ready_next;
  logic [NR-1:0] ghost;
  logic [NR-1:0] acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // A response seen valid and ready here transfers on the next rising edge.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_ovf", 64'(rsp_ovf), 64'(mon_e.ovf));
      end
      if (rsp_seen == 0) first_cyc = cyc;
      last_cyc = cyc;
      rsp_seen++;
    end
  end

  task automatic push(input int id, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] d, input logic o);
    pend_t p;
    exp_t  e;
    p.id = id; p.a = a; p.b = b;
    e.id = id; e.data = d; e.ovf = o;
    pend_q.push_back(p);
    exp_q.push_back(e);
  endtask

  task automatic drive_heads();
    logic found;
    req_valid = ghost;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NR; i++) begin
      found = 1'b0;
      for (int j = 0; j < pend_q.size(); j++) begin
        if (!found && pend_q[j].id == i) begin
          found = 1'b1;
          req_valid[i] = 1'b1;
          req_a[i*DW +: DW] = pend_q[j].a;
          req_b[i*DW +: DW] = pend_q[j].b;
        end
      end
    end
  endtask

  // Entered and left at a falling edge.
  task automatic step();
    logic done;
    acc = req_valid & req_ready;
    if (ghost != '0) check("ghost_acc", 64'(acc & ghost), 64'd0);
    @(posedge clk);
    #1;
    rsp_ready = rsp_ready_next;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        done = 1'b0;
        for (int j = 0; j < pend_q.size(); j++) begin
          if (!done && pend_q[j].id == i) begin
            done = 1'b1;
            pend_q.delete(j);
          end
        end
      end
    end
    drive_heads();
    @(negedge clk);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((pend_q.size() != 0 || exp_q.size() != 0 || rsp_valid) && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(exp_q.size() + pend_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ghost = '0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    pend_q.delete();
    exp_q.delete();
    rsp_ready = 1'b1;
    rsp_ready_next = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state, with all requesters asking.
    reset = 1'b1;
    ghost = '0;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    rsp_ready_next = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_data", rsp_data, 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_ovf", 64'(rsp_ovf), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);

    // 1.5 * 2.0 with latency check.
    do_reset();
    push(0, 64'h0180_0000_0000_0000, 64'h0200_0000_0000_0000, 64'h0300_0000_0000_0000, 1'b0);
    step();
    check("t1_ready", 64'(req_ready), 64'd1);
    step();
    check("t1_lat_s1", 64'(rsp_valid), 64'd0);
    step();
    check("t1_lat_s2", 64'(rsp_valid), 64'd1);
    run_until_idle("t1_drain", 10);

    // Sign, overflow and truncation cases, one at a time.
    push(2, 64'hFF80_0000_0000_0000, 64'h0080_0000_0000_0000, 64'hFFC0_0000_0000_0000, 1'b0);
    run_until_idle("t2_drain", 10);
    push(1, 64'h1000_0000_0000_0000, 64'h1000_0000_0000_0000, 64'h0, 1'b1);
    run_until_idle("t3_drain", 10);
    push(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1);
    run_until_idle("min_sq_drain", 10);
    push(3, 64'hFF00_0000_0000_0000, 64'hFF00_0000_0000_0000, 64'h0100_0000_0000_0000, 1'b0);
    run_until_idle("neg1_sq_drain", 10);
    push(0, 64'h1, 64'hFF80_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_until_idle("floor_neg_drain", 10);
    push(0, 64'h1, 64'h0080_0000_0000_0000, 64'h0, 1'b0);
    run_until_idle("floor_pos_drain", 10);

    // All requesters valid: strict rotation, back-to-back.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        push(i, 64'(i) << 56, 64'(i) << 56, 64'(i * i) << 56, 1'b0);
    rsp_seen = 0;
    run_until_idle("rot_drain", 30);
    check("rot_count", 64'(rsp_seen), 64'd8);
    check("rot_span", 64'(last_cyc - first_cyc), 64'd7);

    // Single requester continuously valid.
    do_reset();
    for (int k = 1; k <= 4; k++)
      push(1, 64'(k) << 56, 64'h0200_0000_0000_0000, 64'(2 * k) << 56, 1'b0);
    rsp_seen = 0;
    run_until_idle("single_drain", 20);
    check("single_span", 64'(last_cyc - first_cyc), 64'd3);

    // Backpressure: first response held for 5 cycles.
    do_reset();
    rsp_ready = 1'b0;
    rsp_ready_next = 1'b0;
    push(0, 64'h0200_0000_0000_0000, 64'h0300_0000_0000_0000, 64'h0600_0000_0000_0000, 1'b0);
    push(1, 64'hFE00_0000_0000_0000, 64'h0300_0000_0000_0000, 64'hFA00_0000_0000_0000, 1'b0);
    push(2, 64'h0040_0000_0000_0000, 64'h0400_0000_0000_0000, 64'h0100_0000_0000_0000, 1'b0);
    rsp_seen = 0;
    for (int n = 0; n < 10 && !rsp_valid; n++) step();
    check("stall_first_valid", 64'(rsp_valid), 64'd1);
    for (int n = 0; n < 5; n++) begin
      step();
      check("stall_hold_valid", 64'(rsp_valid), 64'd1);
      check("stall_hold_data", rsp_data, 64'h0600_0000_0000_0000);
      check("stall_hold_id", 64'(rsp_id), 64'd0);
      check("stall_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready_next = 1'b1;
    run_until_idle("stall_drain", 20);
    check("stall_count", 64'(rsp_seen), 64'd3);

    // A request withdrawn before acceptance must not move the pointer.
    do_reset();
    rsp_ready = 1'b0;
    rsp_ready_next = 1'b0;
    push(0, 64'h0100_0000_0000_0000, 64'h0100_0000_0000_0000, 64'h0100_0000_0000_0000, 1'b0);
    push(1, 64'h0200_0000_0000_0000, 64'h0200_0000_0000_0000, 64'h0400_0000_0000_0000, 1'b0);
    repeat (3) step();
    ghost = 4'b1000;
    repeat (2) begin
      step();
      check("ghost_ready", 64'(req_ready), 64'd0);
    end
    ghost = '0;
    push(2, 64'h0300_0000_0000_0000, 64'hFF00_0000_0000_0000, 64'hFD00_0000_0000_0000, 1'b0);
    push(0, 64'h0080_0000_0000_0000, 64'h0080_0000_0000_0000, 64'h0040_0000_0000_0000, 1'b0);
    rsp_ready_next = 1'b1;
    run_until_idle("ghost_drain", 20);

    // Reset with both stages full flushes them and restores priority.
    do_reset();
    rsp_ready = 1'b0;
    rsp_ready_next = 1'b0;
    pend_q.push_back('{id: 1, a: 64'h0100_0000_0000_0000, b: 64'h0100_0000_0000_0000});
    pend_q.push_back('{id: 2, a: 64'h0100_0000_0000_0000, b: 64'h0100_0000_0000_0000});
    repeat (3) step();
    check("flush_pre_valid", 64'(rsp_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("flush_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    pend_q.delete();
    req_valid = '0;
    @(negedge clk);
    check("flush_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    rsp_ready_next = 1'b1;
    for (int i = 0; i < NR; i++)
      push(i, 64'(i + 1) << 56, 64'h0100_0000_0000_0000, 64'(i + 1) << 56, 1'b0);
    drive_heads();
    @(negedge clk);
    check("flush_first_grant", 64'(req_ready), 64'd1);
    run_until_idle("flush_drain", 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
